frame_diff_scanner: RTL and testbench



---
 rtl/frame_diff_scanner.sv | 178 +++++++++++++++++
 tb/tb_frame_diff_scanner.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_diff_scanner.sv
// frame_diff_scanner: walks a GRID_W x GRID_H tile grid, priority-encodes the
// per-tile object flags and requests a redraw only for tiles whose code differs
// from the previous frame (or every tile on a forced frame). Each request is
// held until the display driver acknowledges it with cmd_done.
module frame_diff_scanner #(
    parameter int GRID_W = 16,
    parameter int GRID_H = 12,
    parameter int XW     = 4,
    parameter int YW     = 4,
    parameter int CODE_W = 3,
    localparam int CNT_W = $clog2(GRID_W * GRID_H + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              full_refresh,
    input  logic              border,
    input  logic              snake_head,
    input  logic              snake_body,
    input  logic              apple,
    input  logic              cmd_done,
    output logic [XW-1:0]     x,
    output logic [YW-1:0]     y,
    output logic [CODE_W-1:0] obj_code,
    output logic              diff,
    output logic              busy,
    output logic              init_cycle,
    output logic              frame_done,
    output logic [CNT_W-1:0]  diff_count
);

    localparam int NTILES = GRID_W * GRID_H;
    localparam int AW     = $clog2(NTILES);

    typedef enum logic [1:0] {IDLE, SCAN, REQ, DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [XW-1:0]       r_x, w_x_nxt;
    logic [YW-1:0]       r_y, w_y_nxt;
    logic [CODE_W-1:0]   r_obj_code, w_obj_nxt;
    logic                r_diff, w_diff_nxt;
    logic                r_force, w_force_nxt;
    logic                r_init, w_init_nxt;
    logic [CNT_W-1:0]    r_diff_count, w_cnt_nxt;
    logic                w_we;

    logic [CODE_W-1:0]   r_mem [NTILES];
    logic [CODE_W-1:0]   w_code;
    logic [CODE_W-1:0]   w_prev_code;
    logic [AW-1:0]       w_idx;
    logic                w_x_end;
    logic                w_last;
    logic                w_hit;
    logic [XW-1:0]       w_adv_x;
    logic [YW-1:0]       w_adv_y;

    // Priority encoder: border beats head beats body beats apple.
    always_comb begin
        w_code = '0;
        if (border)
            w_code = CODE_W'(1);
        else if (snake_head)
            w_code = CODE_W'(2);
        else if (snake_body)
            w_code = CODE_W'(3);
        else if (apple)
            w_code = CODE_W'(4);
    end

    assign w_idx       = AW'(r_y) * AW'(GRID_W) + AW'(r_x);
    assign w_prev_code = r_mem[w_idx];
    assign w_x_end     = (r_x == XW'(GRID_W - 1));
    assign w_last      = w_x_end && (r_y == YW'(GRID_H - 1));
    assign w_hit       = r_force || (w_code != w_prev_code);
    assign w_adv_x     = w_x_end ? '0 : r_x + XW'(1);
    assign w_adv_y     = w_x_end ? r_y + YW'(1) : r_y;

    // Next-state and next-datapath logic for the scan FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_obj_nxt   = r_obj_code;
        w_diff_nxt  = r_diff;
        w_force_nxt = r_force;
        w_init_nxt  = r_init;
        w_cnt_nxt   = r_diff_count;
        w_we        = 1'b0;
        case (r_state)
            IDLE: begin
                w_x_nxt = '0;
                w_y_nxt = '0;
                if (start) begin
                    w_force_nxt = full_refresh | r_init;
                    w_cnt_nxt   = '0;
                    w_state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (w_hit) begin
                    // Memory is updated when the request is issued, not on ack.
                    w_we        = 1'b1;
                    w_obj_nxt   = w_code;
                    w_diff_nxt  = 1'b1;
                    w_cnt_nxt   = r_diff_count + CNT_W'(1);
                    w_state_nxt = REQ;
                end else if (w_last) begin
                    w_x_nxt     = '0;
                    w_y_nxt     = '0;
                    w_state_nxt = DONE;
                end else begin
                    w_x_nxt = w_adv_x;
                    w_y_nxt = w_adv_y;
                end
            end
            REQ: begin
                if (r_diff && cmd_done) begin
                    w_diff_nxt = 1'b0;
                    if (w_last) begin
                        w_x_nxt     = '0;
                        w_y_nxt     = '0;
                        w_state_nxt = DONE;
                    end else begin
                        w_x_nxt     = w_adv_x;
                        w_y_nxt     = w_adv_y;
                        w_state_nxt = SCAN;
                    end
                end
            end
            DONE: begin
                w_x_nxt     = '0;
                w_y_nxt     = '0;
                w_init_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State and datapath registers; reset returns every control value to idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_obj_code   <= '0;
            r_diff       <= 1'b0;
            r_force      <= 1'b0;
            r_init       <= 1'b1;
            r_diff_count <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_x          <= w_x_nxt;
            r_y          <= w_y_nxt;
            r_obj_code   <= w_obj_nxt;
            r_diff       <= w_diff_nxt;
            r_force      <= w_force_nxt;
            r_init       <= w_init_nxt;
            r_diff_count <= w_cnt_nxt;
        end
    end

    // Previous-frame code memory; deliberately not reset, init_cycle covers it.
    always_ff @(posedge clk) begin
        if (w_we)
            r_mem[w_idx] <= w_code;
    end

    assign x          = r_x;
    assign y          = r_y;
    assign obj_code   = r_obj_code;
    assign diff       = r_diff;
    assign busy       = (r_state == SCAN) || (r_state == REQ);
    assign init_cycle = r_init;
    assign frame_done = (r_state == DONE);
    assign diff_count = r_diff_count;

endmodule

// File: tb/tb_frame_diff_scanner.sv
// Testbench for frame_diff_scanner: a bench-side tile map drives the flags,
// a reference model predicts the requests of each frame into a queue, and a
// monitor pops and compares every request as the DUT raises diff.
module tb_frame_diff_scanner;

    localparam int GW = 16;
    localparam int GH = 12;
    localparam int NT = GW * GH;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       full_refresh;
    logic       border, snake_head, snake_body, apple;
    logic       cmd_done;
    logic [3:0] x, y;
    logic [2:0] obj_code;
    logic       diff, busy, init_cycle, frame_done;
    logic [7:0] diff_count;

    frame_diff_scanner #(.GRID_W(GW), .GRID_H(GH), .XW(4), .YW(4), .CODE_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .full_refresh(full_refresh),
        .border(border), .snake_head(snake_head), .snake_body(snake_body),
        .apple(apple), .cmd_done(cmd_done), .x(x), .y(y), .obj_code(obj_code),
        .diff(diff), .busy(busy), .init_cycle(init_cycle),
        .frame_done(frame_done), .diff_count(diff_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int code;
    } req_t;

    typedef struct {
        int op;
        bit fr;
        bit mid;
        int exp_cnt;
    } vec_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    req_t sbq[$];
    logic mb  [GW][GH];
    logic mh  [GW][GH];
    logic mbd [GW][GH];
    logic ma  [GW][GH];
    int   prev_code [NT];
    bit   model_init;
    bit   resp_en;
    int   fd_cnt;
    vec_t vt [8];

    // Flags follow the presented coordinates combinationally.
    always_comb begin
        border     = 1'b0;
        snake_head = 1'b0;
        snake_body = 1'b0;
        apple      = 1'b0;
        if (int'(y) < GH) begin
            border     = mb[x][y];
            snake_head = mh[x][y];
            snake_body = mbd[x][y];
            apple      = ma[x][y];
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int code_of(input int xx, input int yy);
        if (mb[xx][yy])       return 1;
        else if (mh[xx][yy])  return 2;
        else if (mbd[xx][yy]) return 3;
        else if (ma[xx][yy])  return 4;
        return 0;
    endfunction

    task automatic apply_op(input int op);
        case (op)
            1: mh[4][4] = 1'b1;
            2: begin mh[4][4] = 1'b0; mbd[4][4] = 1'b1; mh[5][4] = 1'b1; end
            3: ma[9][7] = 1'b1;
            4: mh[0][5] = 1'b1;
            6: ma[9][7] = 1'b0;
            7: ma[7][4] = 1'b1;
            default: ;
        endcase
    endtask

    // Reference model: push every tile the next frame should request.
    task automatic build_expect(input bit fr);
        bit   frc;
        int   c;
        req_t r;
        frc = fr | model_init;
        model_init = 1'b0;
        for (int yy = 0; yy < GH; yy++) begin
            for (int xx = 0; xx < GW; xx++) begin
                c = code_of(xx, yy);
                if (frc || c != prev_code[yy*GW + xx]) begin
                    r.x = xx; r.y = yy; r.code = c;
                    sbq.push_back(r);
                end
                prev_code[yy*GW + xx] = c;
            end
        end
    endtask

    task automatic run_frame(input bit fr, input bit mid, input int exp_cnt, input string tag);
        int cyc;
        bit got;
        build_expect(fr);
        fd_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        full_refresh = fr;
        @(posedge clk);
        #1;
        start = 1'b0;
        full_refresh = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 4000) begin
            @(posedge clk);
            cyc++;
            #1;
            got = frame_done;
            start = (mid && cyc == 50);
        end
        start = 1'b0;
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no frame_done, expected one within 4000 cycles", tag);
        end else if (exp_cnt == 0) begin
            check({tag, "_latency"}, cyc, NT);
        end
        check({tag, "_diff_count"}, int'(diff_count), exp_cnt);
        repeat (2) @(negedge clk);
        check({tag, "_init_cycle"}, int'(init_cycle), 0);
        check({tag, "_frame_done_pulses"}, fd_cnt, 1);
        check({tag, "_missing_reqs"}, sbq.size(), 0);
        check({tag, "_busy_after"}, int'(busy), 0);
        sbq.delete();
    endtask

    // Responder: acknowledge each request five cycles after diff rises.
    initial begin
        cmd_done = 1'b0;
        forever begin
            @(negedge clk);
            if (resp_en && diff) begin
                repeat (4) @(negedge clk);
                cmd_done = 1'b1;
                @(negedge clk);
                cmd_done = 1'b0;
            end
        end
    end

    // Monitor: compare each diff rise against the queue head; count frame_done.
    initial begin
        logic pd;
        req_t r;
        pd = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (frame_done) fd_cnt++;
            if (diff && !pd) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_req: got request at (%0d,%0d) code %0d, expected none",
                             x, y, obj_code);
                end else begin
                    r = sbq.pop_front();
                    check("req_x", int'(x), r.x);
                    check("req_y", int'(y), r.y);
                    check("req_code", int'(obj_code), r.code);
                end
            end
            pd = diff;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no end of test, expected finish before 3 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cyc;
        bit  got;
        vt[0] = '{0, 1'b0, 1'b0, 192};
        vt[1] = '{0, 1'b0, 1'b0, 0};
        vt[2] = '{1, 1'b0, 1'b0, 1};
        vt[3] = '{2, 1'b0, 1'b0, 2};
        vt[4] = '{3, 1'b0, 1'b0, 1};
        vt[5] = '{4, 1'b0, 1'b0, 0};
        vt[6] = '{0, 1'b1, 1'b1, 192};
        vt[7] = '{6, 1'b0, 1'b0, 1};

        for (int xx = 0; xx < GW; xx++) begin
            for (int yy = 0; yy < GH; yy++) begin
                mb[xx][yy]  = (xx == 0 || xx == GW-1 || yy == 0 || yy == GH-1);
                mh[xx][yy]  = 1'b0;
                mbd[xx][yy] = 1'b0;
                ma[xx][yy]  = 1'b0;
            end
        end
        for (int i = 0; i < NT; i++) prev_code[i] = 0;
        model_init   = 1'b1;
        resp_en      = 1'b1;
        fd_cnt       = 0;
        rst          = 1'b1;
        start        = 1'b0;
        full_refresh = 1'b0;

        #12;
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_diff", int'(diff), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_init_cycle", int'(init_cycle), 1);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_diff_count", int'(diff_count), 0);
        check("rst_obj_code", int'(obj_code), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            apply_op(vt[i].op);
            run_frame(vt[i].fr, vt[i].mid, vt[i].exp_cnt, $sformatf("vec%0d", i));
        end

        // Reset while a request at (7,4) is pending and unacknowledged.
        resp_en = 1'b0;
        apply_op(7);
        build_expect(1'b0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 500) begin
            @(posedge clk);
            cyc++;
            #1;
            got = diff;
        end
        check("req74_seen", int'(got), 1);
        check("req74_x", int'(x), 7);
        check("req74_y", int'(y), 4);
        check("req74_code", int'(obj_code), 4);
        check("req74_busy", int'(busy), 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_diff", int'(diff), 0);
        check("async_rst_x", int'(x), 0);
        check("async_rst_y", int'(y), 0);
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_init_cycle", int'(init_cycle), 1);
        check("async_rst_diff_count", int'(diff_count), 0);
        check("req74_popped", sbq.size(), 0);
        sbq.delete();
        @(negedge clk);
        rst = 1'b0;
        resp_en = 1'b1;
        model_init = 1'b1;
        run_frame(1'b0, 1'b0, 192, "redraw_after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
